// File: rtl/instruction_decode_if.sv
// Fetch/write-back side to decode stage bundle; decode results back to execute.
interface instruction_decode_if #(
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32,
   parameter int DWIDTH   = 32
);
   logic                d_i_ce;
   logic [IWIDTH-1:0]   d_i_instr;
   logic [PC_WIDTH-1:0] d_i_pc;
   logic                d_i_stall;
   logic                d_i_wb_en;
   logic [4:0]          d_i_wb_addr;
   logic [DWIDTH-1:0]   d_i_wb_data;

   logic                d_o_ce;
   logic [PC_WIDTH-1:0] d_o_pc;
   logic [DWIDTH-1:0]   d_o_rs_data;
   logic [DWIDTH-1:0]   d_o_rt_data;
   logic [DWIDTH-1:0]   d_o_imm;
   logic [4:0]          d_o_dest_addr;
   logic [3:0]          d_o_alu_op;
   logic                d_o_reg_write;
   logic                d_o_mem_read;
   logic                d_o_mem_write;
   logic                d_o_alu_src;
   logic                d_o_mem_to_reg;
   logic                d_o_branch;
   logic                d_o_jump;
   logic [PC_WIDTH-1:0] d_o_jump_target;
   logic                d_o_illegal;

   modport master (
      output d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_wb_en, d_i_wb_addr, d_i_wb_data,
      input  d_o_ce, d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm, d_o_dest_addr, d_o_alu_op,
             d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_alu_src, d_o_mem_to_reg,
             d_o_branch, d_o_jump, d_o_jump_target, d_o_illegal
   );

   modport slave (
      input  d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_wb_en, d_i_wb_addr, d_i_wb_data,
      output d_o_ce, d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm, d_o_dest_addr, d_o_alu_op,
             d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_alu_src, d_o_mem_to_reg,
             d_o_branch, d_o_jump, d_o_jump_target, d_o_illegal
   );
endinterface

// File: rtl/instruction_decode.sv
// MIPS-subset decode stage: register file read with write-back bypass,
// control decode, one pipeline register toward execute.
module instruction_decode #(
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32,
   parameter int DWIDTH   = 32
) (
   input  logic                 d_clk,
   input  logic                 d_rst,
   instruction_decode_if.slave  bus
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_ADDI  = 6'h08,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      FN_ADD = 6'h20,
      FN_SUB = 6'h22,
      FN_AND = 6'h24,
      FN_OR  = 6'h25,
      FN_SLT = 6'h2A
   } funct_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4
   } alu_op_e;

   logic [DWIDTH-1:0]   rf_q [32];

   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic [4:0]          rs_idx;
   logic [4:0]          rt_idx;
   logic [4:0]          rd_idx;
   logic [DWIDTH-1:0]   imm_sext;
   logic [DWIDTH-1:0]   imm_zext;
   logic                wb_hit;
   logic                unused_shamt;

   logic                ce_d,   ce_q;
   logic [PC_WIDTH-1:0] pc_d,   pc_q;
   logic [DWIDTH-1:0]   rs_d,   rs_q;
   logic [DWIDTH-1:0]   rt_d,   rt_q;
   logic [DWIDTH-1:0]   imm_d,  imm_q;
   logic [4:0]          dest_d, dest_q;
   alu_op_e             alu_d,  alu_q;
   logic                rw_d,   rw_q;
   logic                mr_d,   mr_q;
   logic                mw_d,   mw_q;
   logic                asrc_d, asrc_q;
   logic                m2r_d,  m2r_q;
   logic                br_d,   br_q;
   logic                jmp_d,  jmp_q;
   logic [PC_WIDTH-1:0] jt_d,   jt_q;
   logic                ill_d,  ill_q;

   assign opcode       = bus.d_i_instr[31:26];
   assign funct        = bus.d_i_instr[5:0];
   assign rs_idx       = bus.d_i_instr[25:21];
   assign rt_idx       = bus.d_i_instr[20:16];
   assign rd_idx       = bus.d_i_instr[15:11];
   assign imm_sext     = {{(DWIDTH-16){bus.d_i_instr[15]}}, bus.d_i_instr[15:0]};
   assign imm_zext     = {{(DWIDTH-16){1'b0}}, bus.d_i_instr[15:0]};
   assign wb_hit       = bus.d_i_wb_en && (bus.d_i_wb_addr != 5'd0);
   assign unused_shamt = ^bus.d_i_instr[10:6];

   // Decode the incoming instruction into next pipeline contents; a missing
   // fetch strobe produces an all-zero bubble instead.
   always_comb begin
      ce_d   = 1'b0;
      pc_d   = '0;
      rs_d   = '0;
      rt_d   = '0;
      imm_d  = '0;
      dest_d = '0;
      alu_d  = ALU_ADD;
      rw_d   = 1'b0;
      mr_d   = 1'b0;
      mw_d   = 1'b0;
      asrc_d = 1'b0;
      m2r_d  = 1'b0;
      br_d   = 1'b0;
      jmp_d  = 1'b0;
      jt_d   = '0;
      ill_d  = 1'b0;
      if (bus.d_i_ce) begin
         ce_d  = 1'b1;
         pc_d  = bus.d_i_pc;
         jt_d  = {bus.d_i_pc[PC_WIDTH-1:28], bus.d_i_instr[25:0], 2'b00};
         imm_d = imm_sext;
         // Same-edge write-back wins over the stored value; R0 is never stored.
         rs_d  = (wb_hit && bus.d_i_wb_addr == rs_idx) ? bus.d_i_wb_data : rf_q[rs_idx];
         rt_d  = (wb_hit && bus.d_i_wb_addr == rt_idx) ? bus.d_i_wb_data : rf_q[rt_idx];
         case (opcode)
            OP_RTYPE: begin
               rw_d   = 1'b1;
               dest_d = rd_idx;
               case (funct)
                  FN_ADD:  alu_d = ALU_ADD;
                  FN_SUB:  alu_d = ALU_SUB;
                  FN_AND:  alu_d = ALU_AND;
                  FN_OR:   alu_d = ALU_OR;
                  FN_SLT:  alu_d = ALU_SLT;
                  default: begin
                     rw_d   = 1'b0;
                     dest_d = '0;
                     ill_d  = 1'b1;
                  end
               endcase
            end
            OP_ADDI: begin
               asrc_d = 1'b1;
               rw_d   = 1'b1;
               dest_d = rt_idx;
            end
            OP_ANDI: begin
               alu_d  = ALU_AND;
               imm_d  = imm_zext;
               asrc_d = 1'b1;
               rw_d   = 1'b1;
               dest_d = rt_idx;
            end
            OP_ORI: begin
               alu_d  = ALU_OR;
               imm_d  = imm_zext;
               asrc_d = 1'b1;
               rw_d   = 1'b1;
               dest_d = rt_idx;
            end
            OP_LW: begin
               asrc_d = 1'b1;
               mr_d   = 1'b1;
               m2r_d  = 1'b1;
               rw_d   = 1'b1;
               dest_d = rt_idx;
            end
            OP_SW: begin
               asrc_d = 1'b1;
               mw_d   = 1'b1;
            end
            OP_BEQ: begin
               alu_d = ALU_SUB;
               br_d  = 1'b1;
            end
            OP_J:    jmp_d = 1'b1;
            default: ill_d = 1'b1;
         endcase
      end
   end

   // Pipeline register toward execute; stall freezes it.
   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         ce_q   <= 1'b0;
         pc_q   <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         imm_q  <= '0;
         dest_q <= '0;
         alu_q  <= ALU_ADD;
         rw_q   <= 1'b0;
         mr_q   <= 1'b0;
         mw_q   <= 1'b0;
         asrc_q <= 1'b0;
         m2r_q  <= 1'b0;
         br_q   <= 1'b0;
         jmp_q  <= 1'b0;
         jt_q   <= '0;
         ill_q  <= 1'b0;
      end else if (!bus.d_i_stall) begin
         ce_q   <= ce_d;
         pc_q   <= pc_d;
         rs_q   <= rs_d;
         rt_q   <= rt_d;
         imm_q  <= imm_d;
         dest_q <= dest_d;
         alu_q  <= alu_d;
         rw_q   <= rw_d;
         mr_q   <= mr_d;
         mw_q   <= mw_d;
         asrc_q <= asrc_d;
         m2r_q  <= m2r_d;
         br_q   <= br_d;
         jmp_q  <= jmp_d;
         jt_q   <= jt_d;
         ill_q  <= ill_d;
      end
   end

   // Register file write port; entry 0 is never written and so reads zero.
   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_hit) begin
         rf_q[bus.d_i_wb_addr] <= bus.d_i_wb_data;
      end
   end

   assign bus.d_o_ce          = ce_q;
   assign bus.d_o_pc          = pc_q;
   assign bus.d_o_rs_data     = rs_q;
   assign bus.d_o_rt_data     = rt_q;
   assign bus.d_o_imm         = imm_q;
   assign bus.d_o_dest_addr   = dest_q;
   assign bus.d_o_alu_op      = alu_q;
   assign bus.d_o_reg_write   = rw_q;
   assign bus.d_o_mem_read    = mr_q;
   assign bus.d_o_mem_write   = mw_q;
   assign bus.d_o_alu_src     = asrc_q;
   assign bus.d_o_mem_to_reg  = m2r_q;
   assign bus.d_o_branch      = br_q;
   assign bus.d_o_jump        = jmp_q;
   assign bus.d_o_jump_target = jt_q;
   assign bus.d_o_illegal     = ill_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed cases plus random
// traffic compared against a table-driven reference model.
module tb_instruction_decode;

   logic d_clk = 1'b0;
   logic d_rst = 1'b1;

   instruction_decode_if #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32)) ifc ();

   instruction_decode #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32)) dut (
      .d_clk (d_clk),
      .d_rst (d_rst),
      .bus   (ifc.slave)
   );

   always #5 d_clk = ~d_clk;

   typedef struct packed {
      logic        ce;
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [3:0]  alu;
      logic        rw, mr, mw, asrc, m2r, br, jmp;
      logic [31:0] jt;
      logic        ill;
   } exp_t;

   logic [31:0] mrf [32];
   exp_t        exp_s;
   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, want, $time);
      end
   endtask

   // Reference decode from the instruction-set table.
   function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] s16;
      op    = ins[31:26];
      fn    = ins[5:0];
      s16   = ins[15] ? (32'hFFFF0000 | ins[15:0]) : {16'h0, ins[15:0]};
      e     = '0;
      e.ce  = 1'b1;
      e.pc  = pc;
      e.rs  = mrf[ins[25:21]];
      e.rt  = mrf[ins[20:16]];
      e.jt  = (pc & 32'hF0000000) | ({6'b0, ins[25:0]} << 2);
      e.imm = s16;
      if (op == 6'h00) begin
         e.rw   = 1'b1;
         e.dest = ins[15:11];
         if      (fn == 6'h20) e.alu = 4'd0;
         else if (fn == 6'h22) e.alu = 4'd1;
         else if (fn == 6'h24) e.alu = 4'd2;
         else if (fn == 6'h25) e.alu = 4'd3;
         else if (fn == 6'h2A) e.alu = 4'd4;
         else begin e.rw = 1'b0; e.dest = 5'd0; e.ill = 1'b1; end
      end
      else if (op == 6'h08) begin e.asrc = 1; e.rw = 1; e.dest = ins[20:16]; end
      else if (op == 6'h0C) begin e.alu = 2; e.imm = {16'h0, ins[15:0]}; e.asrc = 1; e.rw = 1; e.dest = ins[20:16]; end
      else if (op == 6'h0D) begin e.alu = 3; e.imm = {16'h0, ins[15:0]}; e.asrc = 1; e.rw = 1; e.dest = ins[20:16]; end
      else if (op == 6'h23) begin e.asrc = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.dest = ins[20:16]; end
      else if (op == 6'h2B) begin e.asrc = 1; e.mw = 1; end
      else if (op == 6'h04) begin e.alu = 1; e.br = 1; end
      else if (op == 6'h02) e.jmp = 1;
      else e.ill = 1;
      return e;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".ce"},   64'(ifc.d_o_ce),          64'(exp_s.ce));
      check({tag, ".pc"},   64'(ifc.d_o_pc),          64'(exp_s.pc));
      check({tag, ".rs"},   64'(ifc.d_o_rs_data),     64'(exp_s.rs));
      check({tag, ".rt"},   64'(ifc.d_o_rt_data),     64'(exp_s.rt));
      check({tag, ".imm"},  64'(ifc.d_o_imm),         64'(exp_s.imm));
      check({tag, ".dest"}, 64'(ifc.d_o_dest_addr),   64'(exp_s.dest));
      check({tag, ".alu"},  64'(ifc.d_o_alu_op),      64'(exp_s.alu));
      check({tag, ".ctl"},  64'({ifc.d_o_reg_write, ifc.d_o_mem_read, ifc.d_o_mem_write,
                                 ifc.d_o_alu_src, ifc.d_o_mem_to_reg, ifc.d_o_branch,
                                 ifc.d_o_jump}),
                            64'({exp_s.rw, exp_s.mr, exp_s.mw, exp_s.asrc, exp_s.m2r,
                                 exp_s.br, exp_s.jmp}));
      check({tag, ".jt"},   64'(ifc.d_o_jump_target), 64'(exp_s.jt));
      check({tag, ".ill"},  64'(ifc.d_o_illegal),     64'(exp_s.ill));
   endtask

   task automatic model_reset();
      foreach (mrf[i]) mrf[i] = '0;
      exp_s = '0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare after it.
   task automatic step(input string tag, input logic ce, input logic [31:0] instr,
                       input logic [31:0] pc, input logic stall, input logic wb_en,
                       input logic [4:0] wb_addr, input logic [31:0] wb_data);
      ifc.d_i_ce      = ce;
      ifc.d_i_instr   = instr;
      ifc.d_i_pc      = pc;
      ifc.d_i_stall   = stall;
      ifc.d_i_wb_en   = wb_en;
      ifc.d_i_wb_addr = wb_addr;
      ifc.d_i_wb_data = wb_data;
      @(posedge d_clk);
      if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
      if (!stall) exp_s = ce ? model_decode(instr, pc) : '0;
      #1;
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  ops [9];
      logic [5:0]  fns [6];
      logic [31:0] ins;
      ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom);
      else ins[31:26] = ops[$urandom_range(0, 8)];
      if (ins[31:26] == 6'h00) begin
         if ($urandom_range(0, 7) == 0) ins[5:0] = 6'($urandom);
         else ins[5:0] = fns[$urandom_range(0, 5)];
      end
      return ins;
   endfunction

   initial begin
      ifc.d_i_ce = 0; ifc.d_i_instr = '0; ifc.d_i_pc = '0; ifc.d_i_stall = 0;
      ifc.d_i_wb_en = 0; ifc.d_i_wb_addr = '0; ifc.d_i_wb_data = '0;
      model_reset();
      repeat (2) @(posedge d_clk);
      #1;
      check_all("reset");
      d_rst = 1'b0;

      // Write-back then decode of add $10,$8,$9
      step("wb8",  0, 32'h0, 32'h0, 0, 1, 5'd8, 32'h10);
      step("wb9",  0, 32'h0, 32'h0, 0, 1, 5'd9, 32'h3);
      step("add",  1, 32'h01095020, 32'h4, 0, 0, 5'd0, 32'h0);
      check("add.rs_const",   64'(ifc.d_o_rs_data),   64'h10);
      check("add.rt_const",   64'(ifc.d_o_rt_data),   64'h3);
      check("add.dest_const", 64'(ifc.d_o_dest_addr), 64'd10);
      check("add.pc_const",   64'(ifc.d_o_pc),        64'h4);

      // Immediate extension
      step("addi", 1, 32'h2001FFFF, 32'h8, 0, 0, 5'd0, 32'h0);
      check("addi.imm_const", 64'(ifc.d_o_imm), 64'hFFFFFFFF);
      step("ori",  1, 32'h3401FFFF, 32'hC, 0, 0, 5'd0, 32'h0);
      check("ori.imm_const",  64'(ifc.d_o_imm), 64'h0000FFFF);

      // Bypass on lw and R0 write ignored
      step("lw",   1, 32'h8C620004, 32'h10, 0, 1, 5'd3, 32'hABCD);
      check("lw.bypass_const", 64'(ifc.d_o_rs_data), 64'hABCD);
      step("wb0",  0, 32'h0, 32'h0, 0, 1, 5'd0, 32'h1234);
      step("rd0",  1, 32'h00000020, 32'h14, 0, 0, 5'd0, 32'h0);
      check("r0.zero_const", 64'(ifc.d_o_rs_data), 64'h0);

      // Jump, then stall with changing inputs, then bubble
      step("j",    1, 32'h08000040, 32'h40000000, 0, 0, 5'd0, 32'h0);
      check("j.jt_const", 64'(ifc.d_o_jump_target), 64'h40000100);
      for (int i = 0; i < 3; i++)
         step("stall", 1'(i & 1), rand_instr(), $urandom, 1, 1, 5'(11 + i), $urandom);
      check("stall.jump_const", 64'(ifc.d_o_jump), 64'd1);
      step("bubble", 0, 32'h01095020, 32'h18, 0, 0, 5'd0, 32'h0);
      check("bubble.ce_const", 64'(ifc.d_o_ce), 64'd0);

      // Illegal encodings
      step("ill3f", 1, 32'hFC000000, 32'h1C, 0, 0, 5'd0, 32'h0);
      check("ill3f.ill_const", 64'(ifc.d_o_illegal), 64'd1);
      step("nop",   1, 32'h00000000, 32'h20, 0, 0, 5'd0, 32'h0);

      // Asynchronous reset between edges
      step("wb5",  1, 32'h00A00020, 32'h24, 0, 1, 5'd5, 32'h55);
      #2;
      d_rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      d_rst = 1'b0;
      step("rd5",  1, 32'h00A00020, 32'h28, 0, 0, 5'd0, 32'h0);
      check("rd5.zero_const", 64'(ifc.d_o_rs_data), 64'h0);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         step("rand", $urandom_range(0, 4) != 0, rand_instr(), $urandom,
              $urandom_range(0, 5) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
